// File: rtl/spi_slave_rx.sv
// ---------------------------------------------------------------------------
// spi_slave_rx
//
// Receiver for the 9-bit display SPI link (the far end of the master that
// drives the ILI panel). All four SPI lines are oversampled in the local clk
// domain through a SYNC_STAGES-deep synchronizer. Each {dc, payload} word is
// reassembled and announced with a one-cycle data_valid pulse.
//
// Parameters:
//   DATA_SIZE   - word width; MSB is the D/C flag, low DATA_SIZE-1 bits are
//                 the payload (minimum 4)
//   SYNC_STAGES - synchronizer flops per SPI input (minimum 2)
//
// Ports:
//   clk         - system clock, rising edge
//   rst         - asynchronous active-high reset
//   spi_sck     - SPI clock, payload bits sampled on its rising edge
//   spi_mosi    - serial data, MSB first
//   spi_dc      - D/C line (1 = data, 0 = command)
//   spi_cs      - chip select, active low
//   data_out    - last completed word {dc, payload}
//   data_valid  - one-cycle pulse when data_out updates
//   busy        - synchronized chip select is active
//   frame_error - one-cycle pulse when a partial word is aborted
//
// Build option:
//   SPI_RX_FRAME_ERR_EN - when defined, abort detection drives frame_error;
//                         otherwise frame_error is tied low and partial words
//                         are dropped silently.
// ---------------------------------------------------------------------------
module spi_slave_rx #(
    parameter int DATA_SIZE   = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_sck,
    input  logic                 spi_mosi,
    input  logic                 spi_dc,
    input  logic                 spi_cs,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 data_valid,
    output logic                 busy,
    output logic                 frame_error
);

    // The shift register holds the payload bits received before the final
    // one; the final bit goes straight from the synchronizer into data_out.
    localparam int SHIFT_W = DATA_SIZE - 2;
    localparam int CNT_W   = $clog2(DATA_SIZE);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_SIZE - 2);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    // -----------------------------------------------------------------------
    // Input synchronizers. Bit 0 is the first stage; the last stage is the
    // synchronized value. Reset values keep the bus looking idle.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_reg;
    logic [SYNC_STAGES-1:0] cs_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic [SYNC_STAGES-1:0] dc_sync_reg;

    // Tracks how many real samples have entered the synchronizer since
    // reset; the last bit is set once the synchronized outputs no longer
    // reflect reset values.
    logic [SYNC_STAGES-1:0] prime_reg;

    logic sck_prev_reg;
    logic cs_prev_reg;

    // Set once a genuinely high chip select has been seen after reset. A
    // frame that was already in progress at reset release therefore never
    // opens SHIFT; the receiver waits for a clean cs falling edge.
    logic armed_reg;

    logic sck_s;
    logic cs_s;
    logic mosi_s;
    logic dc_s;

    assign sck_s  = sck_sync_reg[SYNC_STAGES-1];
    assign cs_s   = cs_sync_reg[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];
    assign dc_s   = dc_sync_reg[SYNC_STAGES-1];

    logic sck_rise;
    logic cs_rise;
    logic cs_fall;

    assign sck_rise = sck_s & ~sck_prev_reg;
    assign cs_rise  = cs_s & ~cs_prev_reg;
    assign cs_fall  = ~cs_s & cs_prev_reg & armed_reg;

    // -----------------------------------------------------------------------
    // Receive state
    // -----------------------------------------------------------------------
    logic [0:0]           state_reg,      state_next;
    logic [CNT_W-1:0]     count_reg,      count_next;
    logic [SHIFT_W-1:0]   shift_reg,      shift_next;
    logic [DATA_SIZE-1:0] data_out_reg,   data_out_next;
    logic                 data_valid_reg, data_valid_next;
    logic                 complete;

    assign complete = (state_reg == SHIFT) && sck_rise && (count_reg == LAST_BIT);

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        shift_next      = shift_reg;
        data_out_next   = data_out_reg;
        data_valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                count_next = '0;
                if (cs_fall) begin
                    state_next = SHIFT;
                end
            end

            default: begin
                if (sck_rise) begin
                    if (count_reg == LAST_BIT) begin
                        // dc is taken at the same edge as the final payload
                        // bit, so a D/C change between words is honoured.
                        data_out_next   = {dc_s, shift_reg, mosi_s};
                        data_valid_next = 1'b1;
                        count_next      = '0;
                    end else begin
                        shift_next = {shift_reg[SHIFT_W-2:0], mosi_s};
                        count_next = count_reg + CNT_W'(1);
                    end
                end
                // cs rising takes priority for the counter, but a word whose
                // final edge lands in the same cycle has already completed
                // above and is kept.
                if (cs_rise) begin
                    state_next = IDLE;
                    count_next = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_reg   <= '1;
            cs_sync_reg    <= '1;
            mosi_sync_reg  <= '0;
            dc_sync_reg    <= '1;
            prime_reg      <= '0;
            sck_prev_reg   <= 1'b1;
            cs_prev_reg    <= 1'b1;
            armed_reg      <= 1'b0;
            state_reg      <= IDLE;
            count_reg      <= '0;
            shift_reg      <= '0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
        end else begin
            sck_sync_reg   <= {sck_sync_reg[SYNC_STAGES-2:0], spi_sck};
            cs_sync_reg    <= {cs_sync_reg[SYNC_STAGES-2:0], spi_cs};
            mosi_sync_reg  <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
            dc_sync_reg    <= {dc_sync_reg[SYNC_STAGES-2:0], spi_dc};
            prime_reg      <= {prime_reg[SYNC_STAGES-2:0], 1'b1};
            sck_prev_reg   <= sck_s;
            cs_prev_reg    <= cs_s;
            if (prime_reg[SYNC_STAGES-1] && cs_s) begin
                armed_reg <= 1'b1;
            end
            state_reg      <= state_next;
            count_reg      <= count_next;
            shift_reg      <= shift_next;
            data_out_reg   <= data_out_next;
            data_valid_reg <= data_valid_next;
        end
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign busy       = ~cs_s;

    // -----------------------------------------------------------------------
    // Abort reporting
    // -----------------------------------------------------------------------
`ifdef SPI_RX_FRAME_ERR_EN
    logic abort;
    logic frame_error_reg;

    // A word that finishes on the same synchronized cycle as cs rising is
    // not an abort.
    assign abort = (state_reg == SHIFT) && cs_rise && (count_reg != '0) && !complete;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_error_reg <= 1'b0;
        end else begin
            frame_error_reg <= abort;
        end
    end

    assign frame_error = frame_error_reg;
`else
    assign frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
module tb_spi_slave_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_dc;
    logic       spi_cs;
    logic [8:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       frame_error;

`ifdef SPI_RX_FRAME_ERR_EN
    localparam int FE_EXP = 1;
`else
    localparam int FE_EXP = 0;
`endif

    int checks = 0;
    int passed = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;

    spi_slave_rx #(
        .DATA_SIZE  (9),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_dc     (spi_dc),
        .spi_cs     (spi_cs),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle: a pulse wider than one cycle is
    // counted more than once.
    always @(negedge clk) begin
        if (data_valid === 1'b1) dv_cnt <= dv_cnt + 1;
        if (frame_error === 1'b1) fe_cnt <= fe_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        tick(3);
    endtask

    task automatic cs_high();
        tick(2);
        spi_cs = 1'b1;
        tick(4);
    endtask

    task automatic send_bit(input logic dc, input logic b);
        spi_dc   = dc;
        spi_mosi = b;
        tick(2);
        spi_sck = 1'b1;
        tick(2);
        spi_sck = 1'b0;
        tick(1);
    endtask

    task automatic send_bits(input logic dc, input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(dc, v[7-i]);
    endtask

    task automatic test_reset();
        rst = 1'b1; spi_sck = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0; spi_dc = 1'b0;
        tick(3);
        checks++; if (data_out !== 9'h000) $display("FAIL reset_data_out: got %h required %h", data_out, 9'h000); else passed++;
        checks++; if (data_valid !== 1'b0) $display("FAIL reset_data_valid: got %b required 0", data_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else passed++;
        checks++; if (frame_error !== 1'b0) $display("FAIL reset_frame_error: got %b required 0", frame_error); else passed++;
        rst = 1'b0;
        tick(4);
        $display("reset: outputs checked");
    endtask

    task automatic test_data_word();
        int d0, f0;
        d0 = dv_cnt; f0 = fe_cnt;
        cs_low();
        send_bits(1'b1, 8'h2A, 7);
        spi_dc = 1'b1; spi_mosi = 1'b0;
        tick(2);
        spi_sck = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (data_valid !== 1'b0) $display("FAIL latency_cycle2: got %b required 0", data_valid); else passed++;
        @(posedge clk); #1;
        checks++; if (data_valid !== 1'b1) $display("FAIL latency_cycle3: got %b required 1", data_valid); else passed++;
        @(posedge clk); #1;
        checks++; if (data_valid !== 1'b0) $display("FAIL pulse_width: got %b required 0", data_valid); else passed++;
        @(negedge clk);
        spi_sck = 1'b0;
        tick(1);
        cs_high();
        checks++; if (data_out !== 9'h12A) $display("FAIL data_word_out: got %h required %h", data_out, 9'h12A); else passed++;
        checks++; if (dv_cnt - d0 !== 1) $display("FAIL data_word_valid_count: got %0d required 1", dv_cnt - d0); else passed++;
        checks++; if (fe_cnt - f0 !== 0) $display("FAIL data_word_frame_error: got %0d required 0", fe_cnt - f0); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL data_word_busy_after: got %b required 0", busy); else passed++;
        $display("data word: data_out=%h", data_out);
    endtask

    task automatic test_command_word();
        int d0;
        d0 = dv_cnt;
        cs_low();
        send_bits(1'b0, 8'h36, 8);
        cs_high();
        checks++; if (data_out !== 9'h036) $display("FAIL command_out: got %h required %h", data_out, 9'h036); else passed++;
        checks++; if (dv_cnt - d0 !== 1) $display("FAIL command_valid_count: got %0d required 1", dv_cnt - d0); else passed++;
        $display("command word: data_out=%h", data_out);
    endtask

    task automatic test_back_to_back();
        int d0, f0;
        d0 = dv_cnt; f0 = fe_cnt;
        cs_low();
        checks++; if (busy !== 1'b1) $display("FAIL b2b_busy_start: got %b required 1", busy); else passed++;
        send_bits(1'b0, 8'h2A, 8);
        tick(2);
        checks++; if (data_out !== 9'h02A) $display("FAIL b2b_first_out: got %h required %h", data_out, 9'h02A); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL b2b_busy_mid: got %b required 1", busy); else passed++;
        send_bits(1'b1, 8'hFF, 8);
        tick(2);
        checks++; if (data_out !== 9'h1FF) $display("FAIL b2b_second_out: got %h required %h", data_out, 9'h1FF); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL b2b_busy_end: got %b required 1", busy); else passed++;
        cs_high();
        checks++; if (dv_cnt - d0 !== 2) $display("FAIL b2b_valid_count: got %0d required 2", dv_cnt - d0); else passed++;
        checks++; if (fe_cnt - f0 !== 0) $display("FAIL b2b_frame_error: got %0d required 0", fe_cnt - f0); else passed++;
        $display("back to back: last data_out=%h", data_out);
    endtask

    task automatic test_abort();
        int d0, f0;
        d0 = dv_cnt; f0 = fe_cnt;
        cs_low();
        send_bits(1'b1, 8'h55, 5);
        cs_high();
        checks++; if (fe_cnt - f0 !== FE_EXP) $display("FAIL abort_frame_error: got %0d required %0d", fe_cnt - f0, FE_EXP); else passed++;
        checks++; if (dv_cnt - d0 !== 0) $display("FAIL abort_no_valid: got %0d required 0", dv_cnt - d0); else passed++;
        checks++; if (data_out !== 9'h1FF) $display("FAIL abort_hold_out: got %h required %h", data_out, 9'h1FF); else passed++;
        cs_low();
        send_bits(1'b1, 8'h55, 8);
        cs_high();
        checks++; if (data_out !== 9'h155) $display("FAIL abort_next_out: got %h required %h", data_out, 9'h155); else passed++;
        checks++; if (dv_cnt - d0 !== 1) $display("FAIL abort_next_valid: got %0d required 1", dv_cnt - d0); else passed++;
        checks++; if (fe_cnt - f0 !== FE_EXP) $display("FAIL abort_fe_total: got %0d required %0d", fe_cnt - f0, FE_EXP); else passed++;
        $display("abort: frame errors=%0d data_out=%h", fe_cnt - f0, data_out);
    endtask

    task automatic test_simultaneous();
        int d0, f0;
        d0 = dv_cnt; f0 = fe_cnt;
        cs_low();
        send_bits(1'b0, 8'h81, 7);
        spi_dc = 1'b0; spi_mosi = 1'b1;
        tick(2);
        spi_sck = 1'b1;
        spi_cs  = 1'b1;
        tick(3);
        spi_sck = 1'b0;
        tick(4);
        checks++; if (data_out !== 9'h081) $display("FAIL simul_out: got %h required %h", data_out, 9'h081); else passed++;
        checks++; if (dv_cnt - d0 !== 1) $display("FAIL simul_valid: got %0d required 1", dv_cnt - d0); else passed++;
        checks++; if (fe_cnt - f0 !== 0) $display("FAIL simul_frame_error: got %0d required 0", fe_cnt - f0); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL simul_busy: got %b required 0", busy); else passed++;
        $display("simultaneous end: data_out=%h", data_out);
    endtask

    task automatic test_reset_mid_word();
        int d0, f0;
        cs_low();
        send_bits(1'b1, 8'hC3, 4);
        rst = 1'b1;
        #1;
        checks++; if (data_out !== 9'h000) $display("FAIL rstmid_data_out: got %h required %h", data_out, 9'h000); else passed++;
        checks++; if (data_valid !== 1'b0) $display("FAIL rstmid_data_valid: got %b required 0", data_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b required 0", busy); else passed++;
        checks++; if (frame_error !== 1'b0) $display("FAIL rstmid_frame_error: got %b required 0", frame_error); else passed++;
        tick(3);
        rst = 1'b0;
        tick(3);
        // cs is still low from before reset: this frame must be ignored.
        d0 = dv_cnt; f0 = fe_cnt;
        send_bits(1'b1, 8'h3C, 8);
        tick(2);
        checks++; if (dv_cnt - d0 !== 0) $display("FAIL rstmid_ignored_valid: got %0d required 0", dv_cnt - d0); else passed++;
        cs_high();
        checks++; if (fe_cnt - f0 !== 0) $display("FAIL rstmid_ignored_fe: got %0d required 0", fe_cnt - f0); else passed++;
        checks++; if (data_out !== 9'h000) $display("FAIL rstmid_ignored_out: got %h required %h", data_out, 9'h000); else passed++;
        cs_low();
        send_bits(1'b1, 8'hA5, 8);
        cs_high();
        checks++; if (data_out !== 9'h1A5) $display("FAIL rstmid_next_out: got %h required %h", data_out, 9'h1A5); else passed++;
        checks++; if (dv_cnt - d0 !== 1) $display("FAIL rstmid_next_valid: got %0d required 1", dv_cnt - d0); else passed++;
        $display("reset mid word: data_out=%h", data_out);
    endtask

    task automatic test_sck_noise();
        int d0, f0;
        d0 = dv_cnt; f0 = fe_cnt;
        spi_cs = 1'b1;
        for (int i = 0; i < 16; i++) begin
            spi_mosi = i[0];
            spi_sck  = ~spi_sck;
            tick(2);
        end
        tick(4);
        checks++; if (dv_cnt - d0 !== 0) $display("FAIL noise_valid: got %0d required 0", dv_cnt - d0); else passed++;
        checks++; if (fe_cnt - f0 !== 0) $display("FAIL noise_frame_error: got %0d required 0", fe_cnt - f0); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL noise_busy: got %b required 0", busy); else passed++;
        checks++; if (data_out !== 9'h1A5) $display("FAIL noise_hold_out: got %h required %h", data_out, 9'h1A5); else passed++;
        $display("sck noise: data_out=%h", data_out);
    endtask

    initial begin
        test_reset();
        test_data_word();
        test_command_word();
        test_back_to_back();
        test_abort();
        test_simultaneous();
        test_reset_mid_word();
        test_sck_noise();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
